// File: rtl/load_store_unit.sv
// Load/store sequencer between the control unit and a byte-wide data memory.
// Each 16-bit word access is split into two byte accesses, low byte first, at
// A and A+1. Word accesses at the top address either wrap or are rejected.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WRAP_EN = 0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Req,
  output logic                Ready,
  input  logic                Op_store,
  input  logic                Op_word,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [2*DATA_W-1:0] Wdata,
  output logic                Done,
  output logic                Err,
  output logic [2*DATA_W-1:0] Rdata,
  output logic                Mem_en,
  output logic [ADDR_W-1:0]   Mem_addr,
  output logic [DATA_W-1:0]   Mem_wdata,
  input  logic [DATA_W-1:0]   Mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t                r_state;
  state_t                w_next;
  logic                  r_store;
  logic                  r_word;
  logic [ADDR_W-1:0]     r_addr;
  logic [2*DATA_W-1:0]   r_wdata;
  logic                  r_err;
  logic [2*DATA_W-1:0]   r_rdata;
  logic                  r_mem_en;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  w_reject;

  // A word at the last address cannot be split unless wrapping is enabled
  assign w_reject = Op_word && (Addr == '1) && (WRAP_EN == 0);

  assign Err       = r_err;
  assign Rdata     = r_rdata;
  assign Mem_en    = r_mem_en;
  assign Mem_addr  = r_mem_addr;
  assign Mem_wdata = r_mem_wdata;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus the handshake and completion outputs
  always_comb begin
    w_next = r_state;
    Ready  = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        Ready = 1'b1;
        if (Req) w_next = w_reject ? S_RESP : S_LO;
      end
      S_LO:    w_next = r_word ? S_HI : S_RESP;
      S_HI:    w_next = S_RESP;
      S_RESP: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, memory port drive and load-data assembly. The memory port
  // is registered one state ahead so it holds its last value between accesses.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_store     <= 1'b0;
      r_word      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_store <= Op_store;
            r_word  <= Op_word;
            r_addr  <= Addr;
            r_wdata <= Wdata;
            r_err   <= w_reject;
            if (!w_reject) begin
              r_mem_addr <= Addr;
              r_mem_en   <= Op_store;
              if (Op_store) r_mem_wdata <= Wdata[DATA_W-1:0];
            end
          end
        end
        S_LO: begin
          if (!r_store) begin
            r_rdata[DATA_W-1:0] <= Mem_rdata;
            if (!r_word) r_rdata[2*DATA_W-1:DATA_W] <= '0;
          end
          if (r_word) begin
            r_mem_addr <= r_addr + ADDR_ONE;
            r_mem_en   <= r_store;
            if (r_store) r_mem_wdata <= r_wdata[2*DATA_W-1:DATA_W];
          end else begin
            r_mem_en <= 1'b0;
          end
        end
        S_HI: begin
          r_mem_en <= 1'b0;
          if (!r_store) r_rdata[2*DATA_W-1:DATA_W] <= Mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (no-wrap and wrap) share stimulus,
// each with its own byte memory and transaction-level reference model.
module tb_load_store_unit;

  localparam int AW = 5;
  localparam int DW = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req;
  logic        Op_store;
  logic        Op_word;
  logic [4:0]  Addr;
  logic [15:0] Wdata;

  logic        ready_o [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic        en_o    [2];
  logic [15:0] rdata_o [2];
  logic [4:0]  maddr_o [2];
  logic [7:0]  mwd_o   [2];
  logic [7:0]  mrd     [2];

  logic [7:0]  mem0 [32];
  logic [7:0]  mem1 [32];
  logic        init_mem = 1'b1;
  int          cyc = 0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .WRAP_EN(0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Ready(ready_o[0]), .Op_store(Op_store),
    .Op_word(Op_word), .Addr(Addr), .Wdata(Wdata), .Done(done_o[0]), .Err(err_o[0]),
    .Rdata(rdata_o[0]), .Mem_en(en_o[0]), .Mem_addr(maddr_o[0]),
    .Mem_wdata(mwd_o[0]), .Mem_rdata(mrd[0])
  );

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .WRAP_EN(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Ready(ready_o[1]), .Op_store(Op_store),
    .Op_word(Op_word), .Addr(Addr), .Wdata(Wdata), .Done(done_o[1]), .Err(err_o[1]),
    .Rdata(rdata_o[1]), .Mem_en(en_o[1]), .Mem_addr(maddr_o[1]),
    .Mem_wdata(mwd_o[1]), .Mem_rdata(mrd[1])
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Data_memory models: combinational read, synchronous write on En
  assign mrd[0] = mem0[maddr_o[0]];
  assign mrd[1] = mem1[maddr_o[1]];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= init_val(i);
        mem1[i] <= init_val(i);
      end
    end else begin
      if (en_o[0]) mem0[maddr_o[0]] <= mwd_o[0];
      if (en_o[1]) mem1[maddr_o[1]] <= mwd_o[1];
    end
  end

  function automatic logic [7:0] mem_rd(input int k, input int i);
    return (k == 1) ? mem1[i] : mem0[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic        m_busy  [2];
  int          m_since [2];
  int          m_lat   [2];
  logic        m_st    [2];
  logic        m_wd    [2];
  logic [4:0]  m_addr  [2];
  logic [15:0] m_wdata [2];
  logic        m_err   [2];
  logic [15:0] m_rdata [2];
  logic [4:0]  m_last  [2];
  logic [7:0]  m_mem   [2][32];
  logic        x_en, x_done, x_acc, x_same, x_wrap;
  logic [7:0]  x_wd;
  int          x_nb;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = '0; m_last[k] = '0;
      m_since[k] = 0; m_lat[k] = 0;
      for (int i = 0; i < 32; i++) m_mem[k][i] = init_val(i);
    end
    forever begin
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        if (Rst) begin
          m_busy[k] = 1'b0; m_err[k] = 1'b0; m_rdata[k] = '0; m_last[k] = '0;
          chk($sformatf("dut%0d rst Ready", k), ready_o[k], 1);
          chk($sformatf("dut%0d rst Done", k), done_o[k], 0);
          chk($sformatf("dut%0d rst Err", k), err_o[k], 0);
          chk($sformatf("dut%0d rst Rdata", k), rdata_o[k], 0);
          chk($sformatf("dut%0d rst Mem_en", k), en_o[k], 0);
          chk($sformatf("dut%0d rst Mem_addr", k), maddr_o[k], 0);
          chk($sformatf("dut%0d rst Mem_wdata", k), mwd_o[k], 0);
        end else begin
          x_en = 1'b0;
          x_wd = '0;
          if (m_busy[k]) m_since[k]++;
          x_nb = m_wd[k] ? 2 : 1;
          // byte access number m_since of an accepted, non-rejected op
          if (m_busy[k] && !m_err[k] && m_since[k] <= x_nb) begin
            m_last[k] = m_addr[k] + 5'(m_since[k] - 1);
            if (m_st[k]) begin
              x_en = 1'b1;
              x_wd = (m_since[k] == 1) ? m_wdata[k][7:0] : m_wdata[k][15:8];
              m_mem[k][m_last[k]] = x_wd;
            end
          end
          x_done = m_busy[k] && (m_since[k] == m_lat[k]);
          chk($sformatf("dut%0d Ready", k), ready_o[k], !m_busy[k]);
          chk($sformatf("dut%0d Done", k), done_o[k], x_done);
          chk($sformatf("dut%0d Err", k), err_o[k], m_err[k]);
          chk($sformatf("dut%0d Mem_en", k), en_o[k], x_en);
          chk($sformatf("dut%0d Mem_addr", k), maddr_o[k], m_last[k]);
          if (x_en) chk($sformatf("dut%0d Mem_wdata", k), mwd_o[k], x_wd);
          if (!m_busy[k] || x_done) chk($sformatf("dut%0d Rdata", k), rdata_o[k], m_rdata[k]);
          if (!m_busy[k]) begin
            x_same = 1'b1;
            for (int i = 0; i < 32; i++) if (mem_rd(k, i) !== m_mem[k][i]) x_same = 1'b0;
            chk($sformatf("dut%0d memory", k), x_same, 1);
          end
          x_acc = !m_busy[k] && Req;
          if (x_done) m_busy[k] = 1'b0;
          if (x_acc) begin
            x_wrap     = (k == 1);
            m_busy[k]  = 1'b1;
            m_since[k] = 0;
            m_st[k]    = Op_store;
            m_wd[k]    = Op_word;
            m_addr[k]  = Addr;
            m_wdata[k] = Wdata;
            m_err[k]   = Op_word && (Addr == 5'd31) && !x_wrap;
            m_lat[k]   = m_err[k] ? 1 : (Op_word ? 3 : 2);
            if (!Op_store && !m_err[k])
              m_rdata[k] = Op_word ? {m_mem[k][5'(Addr + 5'd1)], m_mem[k][Addr]}
                                   : {8'h00, m_mem[k][Addr]};
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (ready_o[0] && ready_o[1]) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, " ready timeout"}, 0, 1);
  endtask

  task automatic do_op(input string name, input logic st, input logic wd,
                       input logic [4:0] a, input logic [15:0] wdat,
                       input int exp_lat, input int exp_en,
                       output logic [15:0] rd, output logic er);
    int   lat;
    int   en_cnt;
    logic got;
    wait_ready(name);
    @(posedge Clk); #1;
    Op_store = st; Op_word = wd; Addr = a; Wdata = wdat; Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0;
    lat = 0; en_cnt = 0; got = 1'b0; rd = '0; er = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      lat++;
      if (en_o[0]) en_cnt++;
      if (done_o[0]) begin rd = rdata_o[0]; er = err_o[0]; got = 1'b1; break; end
    end
    if (!got) chk({name, " done timeout"}, 0, 1);
    else begin
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " Mem_en cycles"}, en_cnt, exp_en);
    end
  endtask

  logic        h_st [4];
  logic        h_wd [4];
  logic [4:0]  h_a  [4];
  logic [15:0] h_d  [4];
  int          t_acc [4];

  initial begin
    logic [15:0] rd;
    logic        er;
    logic        ok;
    Rst = 1'b1; Req = 1'b0; Op_store = 1'b0; Op_word = 1'b0; Addr = '0; Wdata = '0;
    @(posedge Clk); #1;
    init_mem = 1'b0;

    // Power-on state
    @(negedge Clk);
    chk("por Ready", ready_o[0], 1);
    chk("por Done", done_o[0], 0);
    chk("por Err", err_o[0], 0);
    chk("por Rdata", rdata_o[0], 0);
    chk("por Mem_en", en_o[0], 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("post-rst Ready", ready_o[0], 1);

    // Word store / load, little-endian at 10, 11
    do_op("wst10", 1'b1, 1'b1, 5'd10, 16'hBEEF, 3, 2, rd, er);
    do_op("wld10", 1'b0, 1'b1, 5'd10, 16'h0000, 3, 0, rd, er);
    chk("wld10 Rdata", rd, 16'hBEEF);
    chk("mem[10]", mem0[10], 8'hEF);
    chk("mem[11]", mem0[11], 8'hBE);

    // Byte store / load; load clears the upper byte
    do_op("bst3", 1'b1, 1'b0, 5'd3, 16'hFF5A, 2, 1, rd, er);
    do_op("bld3", 1'b0, 1'b0, 5'd3, 16'h0000, 2, 0, rd, er);
    chk("bld3 Rdata", rd, 16'h005A);
    chk("bld3 Err", er, 0);

    // Word at top address: rejected without wrap, wraps with it
    do_op("wst31", 1'b1, 1'b1, 5'd31, 16'h7733, 1, 0, rd, er);
    chk("wst31 Err", er, 1);
    wait_ready("wst31 drain");
    chk("nowrap mem[31]", mem0[31], 8'h86);
    chk("nowrap mem[0]", mem0[0], 8'h0B);
    chk("wrap mem[31]", mem1[31], 8'h33);
    chk("wrap mem[0]", mem1[0], 8'h77);
    do_op("bld31", 1'b0, 1'b0, 5'd31, 16'h0000, 2, 0, rd, er);
    chk("bld31 Err cleared", er, 0);
    chk("bld31 Rdata", rd, 16'h0086);

    // Req held high across four mixed ops
    h_st[0] = 1'b1; h_wd[0] = 1'b0; h_a[0] = 5'd20; h_d[0] = 16'h00C3;
    h_st[1] = 1'b0; h_wd[1] = 1'b1; h_a[1] = 5'd10; h_d[1] = 16'h1111;
    h_st[2] = 1'b0; h_wd[2] = 1'b0; h_a[2] = 5'd20; h_d[2] = 16'h2222;
    h_st[3] = 1'b1; h_wd[3] = 1'b1; h_a[3] = 5'd14; h_d[3] = 16'hA55A;
    wait_ready("burst");
    @(posedge Clk); #1;
    Op_store = h_st[0]; Op_word = h_wd[0]; Addr = h_a[0]; Wdata = h_d[0]; Req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge Clk);
        if (ready_o[0]) begin ok = 1'b1; break; end
      end
      if (!ok) chk("burst accept timeout", 0, 1);
      t_acc[i] = cyc;
      @(posedge Clk); #1;
      if (i < 3) begin
        Op_store = h_st[i+1]; Op_word = h_wd[i+1]; Addr = h_a[i+1]; Wdata = h_d[i+1];
      end else begin
        Req = 1'b0;
      end
    end
    chk("burst gap byte", t_acc[1] - t_acc[0], 3);
    chk("burst gap word", t_acc[2] - t_acc[1], 4);
    chk("burst gap byte2", t_acc[3] - t_acc[2], 3);
    wait_ready("burst drain");
    chk("burst Rdata", rdata_o[0], 16'h00C3);
    chk("burst mem[14]", mem0[14], 8'h5A);
    chk("burst mem[15]", mem0[15], 8'hA5);

    // Reset during the high-byte access of a word store
    wait_ready("rst-mid");
    @(posedge Clk); #1;
    Op_store = 1'b1; Op_word = 1'b1; Addr = 5'd5; Wdata = 16'h1234; Req = 1'b1;
    @(posedge Clk); #1;
    Req = 1'b0;
    @(posedge Clk); #1;
    chk("rst-mid in HI Mem_addr", maddr_o[0], 6);
    Rst = 1'b1;
    #1;
    chk("rst-mid Ready", ready_o[0], 1);
    chk("rst-mid Done", done_o[0], 0);
    chk("rst-mid Mem_en", en_o[0], 0);
    chk("rst-mid Mem_addr", maddr_o[0], 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    chk("rst-mid mem[5]", mem0[5], 8'h34);
    chk("rst-mid mem[6]", mem0[6], 8'hE9);

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
